// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and the
// instruction memory (slave): registered address/request out, ack/data back.
interface fetch_ctrl_if;
    logic [31:0] iad;       // instruction-memory address
    logic        imem_req;  // fetch request
    logic        imem_ack;  // memory returns ins this cycle
    logic [31:0] ins;       // instruction data, valid only with imem_ack

    modport master (
        output iad,
        output imem_req,
        input  imem_ack,
        input  ins
    );

    modport slave (
        input  iad,
        input  imem_req,
        output imem_ack,
        output ins
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Multicycle instruction-fetch controller. Samples the PC, runs a req/ack
// access on the instruction-memory bus (with load-wait tolerance and a
// timeout), holds the fetched word in the instruction register until decode
// takes it, then pulses pc_enable for one cycle so the PC register advances.
// Misaligned PCs and memory timeouts raise a sticky fault.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] NOP     = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master imem,
    input  logic [31:0]  pc_i,
    output logic [31:0]  ir_o,
    output logic [31:0]  ir_pc_o,
    output logic [31:0]  pc_plus4_o,
    output logic         ir_valid_o,
    input  logic         ir_take_i,
    input  logic         flush_i,
    output logic         pc_enable_o,
    output logic         fault_o
);

    // Wait counter is one bit wider than needed so it never wraps.
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_ADV   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [31:0]   iad_q, iad_d;
    logic          req_q, req_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          pc_en_q, pc_en_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state and next-output logic for the fetch sequence.
    always_comb begin
        state_d    = state_q;
        iad_d      = iad_q;
        req_d      = req_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        pc_en_d    = 1'b0;
        fault_d    = fault_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pc_i[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    iad_d   = pc_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Flush abandons the access even if the ack arrives now;
                // an ack on the final timeout cycle still completes the fetch.
                if (flush_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (imem.imem_ack) begin
                    ir_d       = imem.ins;
                    ir_pc_d    = iad_q;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_HOLD: begin
                // A redirect discards the held instruction without advancing the PC.
                if (flush_i) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (ir_take_i) begin
                    ir_valid_d = 1'b0;
                    pc_en_d    = 1'b1;
                    state_d    = S_ADV;
                end
            end

            S_ADV: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                req_d      = 1'b0;
                ir_valid_d = 1'b0;
                fault_d    = 1'b1;
            end

            default: begin
                req_d      = 1'b0;
                ir_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            iad_q      <= '0;
            req_q      <= 1'b0;
            ir_q       <= NOP;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            pc_en_q    <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            iad_q      <= iad_d;
            req_q      <= req_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            pc_en_q    <= pc_en_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem.iad      = iad_q;
    assign imem.imem_req = req_q;
    assign ir_o          = ir_q;
    assign ir_pc_o       = ir_pc_q;
    assign pc_plus4_o    = ir_pc_q + 32'd4;
    assign ir_valid_o    = ir_valid_q;
    assign pc_enable_o   = pc_en_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. Inputs change and outputs are sampled
// on the falling edge; fetched words are pushed to a scoreboard when the
// memory acks and popped when ir_valid shows the instruction register.
module tb_fetch_ctrl;

    localparam int unsigned TO    = 16;
    localparam logic [31:0] NOP_V = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] ir, ir_pc, pc_plus4;
    logic        ir_valid, ir_take, flush, pc_enable, fault;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.TIMEOUT(TO), .NOP(NOP_V)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .pc_i        (pc),
        .ir_o        (ir),
        .ir_pc_o     (ir_pc),
        .pc_plus4_o  (pc_plus4),
        .ir_valid_o  (ir_valid),
        .ir_take_i   (ir_take),
        .flush_i     (flush),
        .pc_enable_o (pc_enable),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] sb[$];   // {ins, address} of each expected fetch

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic do_reset(input logic [31:0] p);
        rst = 1'b0;
        flush = 1'b0;
        ir_take = 1'b0;
        bus.imem_ack = 1'b0;
        bus.ins = '0;
        pc = p;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        ir_take = 1'b0;
        bus.imem_ack = 1'b0;
        bus.ins = '0;
        pc = 32'h0001_0000;
        @(negedge clk);
        vectors++; if (bus.iad !== 32'h0) begin miscompares++; $display("FAIL reset_iad: got %h expected %h", bus.iad, 32'h0); end
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        vectors++; if (ir !== NOP_V) begin miscompares++; $display("FAIL reset_ir: got %h expected %h", ir, NOP_V); end
        vectors++; if (ir_pc !== 32'h0) begin miscompares++; $display("FAIL reset_ir_pc: got %h expected 0", ir_pc); end
        vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4: got %h expected 4", pc_plus4); end
        vectors++; if ({ir_valid, pc_enable, fault} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {ir_valid, pc_enable, fault}); end
    endtask

    task automatic test_basic();
        logic [63:0] e;
        do_reset(32'h0001_0000);
        @(negedge clk);   // first FETCH cycle
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL basic_req: got %b expected 1", bus.imem_req); end
        vectors++; if (bus.iad !== 32'h0001_0000) begin miscompares++; $display("FAIL basic_iad: got %h expected 00010000", bus.iad); end
        @(negedge clk);   // second wait cycle
        vectors++; if (bus.imem_req !== 1'b1 || bus.iad !== 32'h0001_0000) begin miscompares++; $display("FAIL basic_wait: got req=%b iad=%h expected req=1 iad=00010000", bus.imem_req, bus.iad); end
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.ins = 32'h2000_0005;
        sb.push_back({32'h2000_0005, bus.iad});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b expected 1", ir_valid); end
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL basic_sb: got empty scoreboard expected entry"); end
        else begin
            e = sb.pop_front();
            if ({ir, ir_pc} !== e) begin miscompares++; $display("FAIL basic_ir: got %h/%h expected %h/%h", ir, ir_pc, e[63:32], e[31:0]); end
        end
        vectors++; if (pc_plus4 !== 32'h0001_0004) begin miscompares++; $display("FAIL basic_pc_plus4: got %h expected 00010004", pc_plus4); end
        vectors++; if (pc_enable !== 1'b0) begin miscompares++; $display("FAIL basic_no_en: got %b expected 0", pc_enable); end
        ir_take = 1'b1;
        @(negedge clk);
        ir_take = 1'b0;
        vectors++; if (pc_enable !== 1'b1 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL basic_adv: got en=%b valid=%b expected en=1 valid=0", pc_enable, ir_valid); end
        @(negedge clk);
        vectors++; if (pc_enable !== 1'b0) begin miscompares++; $display("FAIL basic_en_width: got %b expected 0", pc_enable); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_iad[$];
        logic [31:0] a;
        logic [63:0] e;
        int last_req, n_req, n_en;
        do_reset(32'h0001_0000);
        ir_take = 1'b1;
        exp_iad = '{32'h0001_0000, 32'h0001_0004, 32'h0001_0008, 32'h0001_000C};
        last_req = -1; n_req = 0; n_en = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            if (ir_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin miscompares++; $display("FAIL stream_sb: got empty scoreboard expected entry"); end
                else begin
                    e = sb.pop_front();
                    if ({ir, ir_pc} !== e) begin miscompares++; $display("FAIL stream_ir: got %h/%h expected %h/%h", ir, ir_pc, e[63:32], e[31:0]); end
                end
            end
            if (bus.imem_req === 1'b1) begin
                if (exp_iad.size() > 0) begin
                    a = exp_iad.pop_front();
                    vectors++; if (bus.iad !== a) begin miscompares++; $display("FAIL stream_iad: got %h expected %h", bus.iad, a); end
                end
                if (n_req > 0) begin
                    vectors++; if (cyc - last_req != 4) begin miscompares++; $display("FAIL stream_period: got %0d expected 4", cyc - last_req); end
                end
                last_req = cyc;
                n_req++;
                bus.ins = bus.iad ^ 32'h1357_9BDF;
                bus.imem_ack = 1'b1;
                sb.push_back({bus.iad ^ 32'h1357_9BDF, bus.iad});
            end
            if (pc_enable === 1'b1) begin
                n_en++;
                pc = pc + 32'd4;
            end
        end
        bus.imem_ack = 1'b0;
        ir_take = 1'b0;
        vectors++; if (n_req != 4) begin miscompares++; $display("FAIL stream_reqs: got %0d expected 4", n_req); end
        vectors++; if (n_en != 3) begin miscompares++; $display("FAIL stream_enables: got %0d expected 3", n_en); end
    endtask

    task automatic test_hold_stall();
        logic [63:0] e;
        do_reset(32'h0001_0000);
        @(negedge clk);
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_req: got %b expected 1", bus.imem_req); end
        bus.imem_ack = 1'b1;
        bus.ins = 32'hDEAD_BEEF;
        sb.push_back({32'hDEAD_BEEF, bus.iad});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL stall_sb: got empty scoreboard expected entry"); end
        else begin
            e = sb.pop_front();
            if ({ir, ir_pc} !== e) begin miscompares++; $display("FAIL stall_ir: got %h/%h expected %h/%h", ir, ir_pc, e[63:32], e[31:0]); end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (ir !== 32'hDEAD_BEEF || ir_valid !== 1'b1 || bus.imem_req !== 1'b0 || pc_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got ir=%h valid=%b req=%b en=%b expected ir=deadbeef valid=1 req=0 en=0", ir, ir_valid, bus.imem_req, pc_enable);
            end
        end
        ir_take = 1'b1;
        @(negedge clk);
        ir_take = 1'b0;
        vectors++; if (pc_enable !== 1'b1 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got en=%b valid=%b expected en=1 valid=0", pc_enable, ir_valid); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset(32'h0001_0000);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                n++;
                vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got fault=%b expected 0 at req cycle %0d", fault, n); end
            end else begin
                break;
            end
        end
        vectors++; if (n != TO) begin miscompares++; $display("FAIL timeout_len: got %0d expected %0d", n, TO); end
        vectors++; if (fault !== 1'b1 || bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL timeout_fault: got fault=%b req=%b expected fault=1 req=0", fault, bus.imem_req); end
        bus.imem_ack = 1'b1;
        bus.ins = 32'hCAFE_F00D;
        ir_take = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (fault !== 1'b1 || bus.imem_req !== 1'b0 || ir_valid !== 1'b0 || pc_enable !== 1'b0 || ir !== NOP_V) begin
                miscompares++;
                $display("FAIL timeout_sticky: got fault=%b req=%b valid=%b en=%b ir=%h expected 1/0/0/0/%h", fault, bus.imem_req, ir_valid, pc_enable, ir, NOP_V);
            end
        end
        bus.imem_ack = 1'b0;
        ir_take = 1'b0;
        rst = 1'b0;
        #1;
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b expected 0", fault); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h0001_0000);
        @(negedge clk);
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL areset_req_before: got %b expected 1", bus.imem_req); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (bus.imem_req !== 1'b0 || pc_enable !== 1'b0) begin miscompares++; $display("FAIL areset_drop: got req=%b en=%b expected 0/0", bus.imem_req, pc_enable); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_flush();
        logic [63:0] e;
        do_reset(32'h0001_0000);
        @(negedge clk);
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL flush_req: got %b expected 1", bus.imem_req); end
        flush = 1'b1;
        bus.imem_ack = 1'b1;
        bus.ins = 32'h1111_1111;
        pc = 32'h0002_0000;
        @(negedge clk);
        flush = 1'b0;
        bus.imem_ack = 1'b0;
        vectors++; if (ir_valid !== 1'b0 || ir !== NOP_V || bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL flush_fetch: got valid=%b ir=%h req=%b expected 0/%h/0", ir_valid, ir, bus.imem_req, NOP_V); end
        @(negedge clk);
        vectors++; if (bus.imem_req !== 1'b1 || bus.iad !== 32'h0002_0000) begin miscompares++; $display("FAIL flush_refetch: got req=%b iad=%h expected 1/00020000", bus.imem_req, bus.iad); end
        bus.imem_ack = 1'b1;
        bus.ins = 32'h2222_2222;
        sb.push_back({32'h2222_2222, bus.iad});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL flush_sb: got empty scoreboard expected entry"); end
        else begin
            e = sb.pop_front();
            if ({ir, ir_pc} !== e || ir_valid !== 1'b1) begin miscompares++; $display("FAIL flush_ir: got %h/%h valid=%b expected %h/%h valid=1", ir, ir_pc, ir_valid, e[63:32], e[31:0]); end
        end
        flush = 1'b1;
        ir_take = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ir_take = 1'b0;
        vectors++; if (pc_enable !== 1'b0 || ir_valid !== 1'b0) begin miscompares++; $display("FAIL flush_hold: got en=%b valid=%b expected 0/0", pc_enable, ir_valid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (pc_enable !== 1'b0) begin miscompares++; $display("FAIL flush_no_en: got %b expected 0", pc_enable); end
        end
    endtask

    task automatic test_misaligned();
        do_reset(32'h0001_0002);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++; if (bus.imem_req !== 1'b0 || fault !== 1'b1) begin miscompares++; $display("FAIL misaligned: got req=%b fault=%b expected 0/1", bus.imem_req, fault); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_hold_stall();
        test_timeout();
        test_async_reset();
        test_flush();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
